// File: rtl/capture_readout_sequencer.sv
// Sequences one binarized frame: arm the CCD path, capture exactly one full frame,
// then drain the read FIFO bit-serially into packed words handed to the HPS.
module capture_readout_sequencer #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int WORD_W      = 32,
    parameter int SOF_TIMEOUT = 50000000
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iSTART,
    input  logic              iABORT,
    input  logic              iFVAL,
    input  logic              iDVAL,
    input  logic              iRD_BIT,
    input  logic              iWORD_ACK,
    output logic              oCAP_EN,
    output logic              oLOAD,
    output logic              oRD,
    output logic [WORD_W-1:0] oWORD,
    output logic              oWORD_VALID,
    output logic [8:0]        oROW,
    output logic [9:0]        oCOL,
    output logic              oBUSY,
    output logic              oDONE,
    output logic              oERR,
    output logic [2:0]        oSTATE
);
    localparam int FRAME_PIX   = H_ACTIVE * V_ACTIVE;
    localparam int FRAME_WORDS = FRAME_PIX / WORD_W;
    localparam int TMO_W       = $clog2(SOF_TIMEOUT + 1);
    localparam int WCNT_W      = $clog2(FRAME_WORDS + 1);
    localparam int RCNT_W      = $clog2(WORD_W + 1);
    localparam logic [18:0]       PIX_TARGET = 19'(FRAME_PIX);
    localparam logic [TMO_W-1:0]  TMO_LOAD   = TMO_W'(SOF_TIMEOUT - 1);
    localparam logic [WCNT_W-1:0] LAST_WORD  = WCNT_W'(FRAME_WORDS - 1);
    localparam logic [RCNT_W-1:0] RD_LAST    = RCNT_W'(WORD_W);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARM      = 3'd1,
        S_WAIT_SOF = 3'd2,
        S_CAPTURE  = 3'd3,
        S_READ     = 3'd4,
        S_PRESENT  = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t              state, state_next;
    logic                start_q, fval_q, edge_armed;
    logic                start_rise, fval_rise, fval_fall;
    logic                load_r, load_next, err_r, err_next;
    logic                start_run, arm_tmo, begin_cap, ack_take;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [18:0]         pix_cnt;
    logic [RCNT_W-1:0]   rd_cnt;
    logic [WCNT_W-1:0]   word_cnt;
    logic [WORD_W-1:0]   word_r;
    logic [8:0]          row_r;
    logic [9:0]          col_r;

    // edge_armed suppresses a false edge in the first cycle after reset
    assign start_rise = edge_armed & iSTART & ~start_q;
    assign fval_rise  = edge_armed & iFVAL & ~fval_q;
    assign fval_fall  = edge_armed & ~iFVAL & fval_q;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state  <= S_IDLE;
            load_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            state  <= state_next;
            load_r <= load_next;
            err_r  <= err_next;
        end
    end

    // Handshake: oWORD_VALID holds word/row/col stable until a cycle with iWORD_ACK=1;
    // that cycle completes the transfer and valid drops on the following edge.
    always_comb begin
        state_next = state;
        load_next  = 1'b0;
        err_next   = err_r;
        start_run  = 1'b0;
        arm_tmo    = 1'b0;
        begin_cap  = 1'b0;
        ack_take   = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start_rise) begin
                    state_next = S_ARM;
                    load_next  = 1'b1;
                    err_next   = 1'b0;
                    start_run  = 1'b1;
                end
            end
            S_ARM: begin
                if (!iFVAL) begin
                    state_next = S_WAIT_SOF;
                    arm_tmo    = 1'b1;
                end
            end
            S_WAIT_SOF: begin
                if (fval_rise) begin
                    state_next = S_CAPTURE;
                    begin_cap  = 1'b1;
                end else if (tmo_cnt == '0) begin
                    state_next = S_IDLE;
                    err_next   = 1'b1;
                end
            end
            S_CAPTURE: begin
                if (fval_fall) begin
                    if (pix_cnt == PIX_TARGET) begin
                        state_next = S_READ;
                        load_next  = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                        err_next   = 1'b1;
                    end
                end
            end
            S_READ: begin
                if (rd_cnt == RD_LAST) state_next = S_PRESENT;
            end
            S_PRESENT: begin
                if (iWORD_ACK) begin
                    ack_take   = 1'b1;
                    state_next = (word_cnt == LAST_WORD) ? S_DONE : S_READ;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (iABORT) begin
            state_next = S_IDLE;
            load_next  = 1'b0;
            err_next   = err_r;
            start_run  = 1'b0;
            arm_tmo    = 1'b0;
            begin_cap  = 1'b0;
            ack_take   = 1'b0;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            start_q    <= 1'b0;
            fval_q     <= 1'b0;
            edge_armed <= 1'b0;
            tmo_cnt    <= '0;
            pix_cnt    <= '0;
            rd_cnt     <= '0;
            word_cnt   <= '0;
            word_r     <= '0;
            row_r      <= '0;
            col_r      <= '0;
        end else begin
            start_q    <= iSTART;
            fval_q     <= iFVAL;
            edge_armed <= 1'b1;
            if (arm_tmo)
                tmo_cnt <= TMO_LOAD;
            else if (state == S_WAIT_SOF && tmo_cnt != '0)
                tmo_cnt <= tmo_cnt - TMO_W'(1);
            // the SOF cycle itself may carry a pixel, so seed the count with it
            if (begin_cap)
                pix_cnt <= {18'd0, iDVAL};
            else if (state == S_CAPTURE && iDVAL && pix_cnt != '1)
                pix_cnt <= pix_cnt + 19'd1;
            if (state == S_READ && state_next == S_READ)
                rd_cnt <= rd_cnt + RCNT_W'(1);
            else
                rd_cnt <= '0;
            // bit for strobe k arrives one cycle later; after WORD_W shifts it sits in bit k
            if (state == S_READ && rd_cnt != '0)
                word_r <= {iRD_BIT, word_r[WORD_W-1:1]};
            if (start_run) begin
                word_cnt <= '0;
                row_r    <= '0;
                col_r    <= '0;
            end else if (ack_take && word_cnt != LAST_WORD) begin
                word_cnt <= word_cnt + WCNT_W'(1);
                if (int'(col_r) + WORD_W == H_ACTIVE) begin
                    col_r <= '0;
                    row_r <= row_r + 9'd1;
                end else begin
                    col_r <= col_r + 10'(WORD_W);
                end
            end
        end
    end

    assign oCAP_EN     = (state == S_CAPTURE);
    assign oLOAD       = load_r;
    assign oRD         = (state == S_READ) && (rd_cnt < RD_LAST);
    assign oWORD       = word_r;
    assign oWORD_VALID = (state == S_PRESENT);
    assign oROW        = row_r;
    assign oCOL        = col_r;
    assign oBUSY       = (state != S_IDLE) && (state != S_DONE);
    assign oDONE       = (state == S_DONE);
    assign oERR        = err_r;
    assign oSTATE      = state;
endmodule

// File: tb/tb_capture_readout_sequencer.sv
// Bench for capture_readout_sequencer on a reduced 64x4 frame packed 8 pixels per word.
module tb_capture_readout_sequencer;
    localparam int H      = 64;
    localparam int V      = 4;
    localparam int W      = 8;
    localparam int TMO    = 100;
    localparam int NPIX   = H * V;
    localparam int NWORDS = NPIX / W;
    localparam int SB_W   = W + 19;

    logic         iCLK = 1'b0;
    logic         iRST, iSTART, iABORT, iFVAL, iDVAL, iRD_BIT, iWORD_ACK;
    logic         oCAP_EN, oLOAD, oRD, oWORD_VALID, oBUSY, oDONE, oERR;
    logic [W-1:0] oWORD;
    logic [8:0]   oROW;
    logic [9:0]   oCOL;
    logic [2:0]   oSTATE;

    logic [SB_W-1:0] exp_q[$];
    logic            fifo_bits[NPIX];
    int              rd_ptr = 0;
    int              hold_word = -1;
    int              mon_idx = 0;
    int              load_cnt = 0;
    int              rd_cyc = 0;
    int              checks = 0;
    int              errors = 0;

    capture_readout_sequencer #(
        .H_ACTIVE(H), .V_ACTIVE(V), .WORD_W(W), .SOF_TIMEOUT(TMO)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iABORT(iABORT),
        .iFVAL(iFVAL), .iDVAL(iDVAL), .iRD_BIT(iRD_BIT), .iWORD_ACK(iWORD_ACK),
        .oCAP_EN(oCAP_EN), .oLOAD(oLOAD), .oRD(oRD), .oWORD(oWORD),
        .oWORD_VALID(oWORD_VALID), .oROW(oROW), .oCOL(oCOL), .oBUSY(oBUSY),
        .oDONE(oDONE), .oERR(oERR), .oSTATE(oSTATE)
    );

    // clock / watchdog
    always #5 iCLK = ~iCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Expected words: mode 0 = alternating pixels (8'h55), mode 1 = w*37+11 per word.
    task automatic load_readout(input int mode, input int hw);
        logic [W-1:0] d;
        exp_q.delete();
        rd_ptr    = 0;
        mon_idx   = 0;
        hold_word = hw;
        for (int w = 0; w < NWORDS; w++) begin
            d = (mode == 0) ? W'('h55) : W'(w * 37 + 11);
            exp_q.push_back({d, 9'(w / (H / W)), 10'((w % (H / W)) * W)});
            for (int b = 0; b < W; b++) fifo_bits[w * W + b] = d[b];
        end
    endtask

    task automatic start_pulse(input string name);
        iSTART = 1'b1;
        @(negedge iCLK);
        check({name, "_arm_state"}, oSTATE, 3'd1);
        check({name, "_arm_load"}, oLOAD, 1'b1);
        check({name, "_arm_err_clr"}, oERR, 1'b0);
        check({name, "_arm_addr_clr"}, {oROW, oCOL}, 19'd0);
        iSTART = 1'b0;
        @(negedge iCLK);
    endtask

    task automatic send_frame(input int n_dval, input bit good, input string name);
        iFVAL = 1'b1;
        iDVAL = 1'b0;
        @(negedge iCLK);
        check({name, "_capen_rise"}, oCAP_EN, 1'b1);
        for (int i = 0; i < n_dval; i++) begin
            iDVAL = 1'b1;
            @(negedge iCLK);
            if (i % 16 == 15) begin
                iDVAL = 1'b0;
                @(negedge iCLK);
            end
        end
        iDVAL = 1'b0;
        @(negedge iCLK);
        iFVAL = 1'b0;
        @(negedge iCLK);
        check({name, "_capen_fall"}, oCAP_EN, 1'b0);
        if (good) begin
            check({name, "_read_state"}, oSTATE, 3'd4);
            check({name, "_read_load"}, oLOAD, 1'b1);
        end else begin
            check({name, "_err_state"}, oSTATE, 3'd0);
            check({name, "_err_flag"}, oERR, 1'b1);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int n;
        n = 0;
        while (oSTATE != s && n < budget) begin
            @(negedge iCLK);
            n++;
        end
        check(name, oSTATE, s);
    endtask

    // FIFO model: the bit for a strobe is on iRD_BIT through the following cycle
    initial begin : fifo_model
        logic rd_seen;
        iRD_BIT = 1'b0;
        forever begin
            @(negedge iCLK);
            rd_seen = oRD;
            @(posedge iCLK);
            #1;
            if (rd_seen && rd_ptr < NPIX) begin
                iRD_BIT = fifo_bits[rd_ptr];
                rd_ptr++;
            end else begin
                iRD_BIT = 1'($urandom_range(0, 1));
            end
        end
    end

    // scoreboard monitor and HPS-side acker
    initial begin : monitor
        logic            prev_valid;
        logic [SB_W-1:0] held, got, exp_w;
        int              hold_left;
        prev_valid = 1'b0;
        hold_left  = 0;
        iWORD_ACK  = 1'b0;
        forever begin
            @(negedge iCLK);
            got = {oWORD, oROW, oCOL};
            if (oLOAD) load_cnt++;
            if (oRD) rd_cyc++;
            if (!oWORD_VALID) begin
                iWORD_ACK = 1'b0;
                hold_left = 0;
            end else begin
                if (!prev_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL word_unexpected: got %0h with no word expected", got);
                    end else begin
                        exp_w = exp_q.pop_front();
                        check($sformatf("word%0d", mon_idx), got, exp_w);
                    end
                    held      = got;
                    hold_left = (mon_idx == hold_word) ? 10 : 0;
                    mon_idx++;
                end else begin
                    check($sformatf("hold_stable_w%0d", mon_idx - 1), got, held);
                    check($sformatf("hold_no_rd_w%0d", mon_idx - 1), oRD, 1'b0);
                end
                iWORD_ACK = (hold_left == 0);
                if (hold_left > 0) hold_left--;
            end
            prev_valid = oWORD_VALID;
        end
    end

    initial begin : stimulus
        int n;
        int cap_hi;
        iRST   = 1'b1;
        iSTART = 1'b1;
        iABORT = 1'b0;
        iFVAL  = 1'b0;
        iDVAL  = 1'b0;
        repeat (3) @(negedge iCLK);
        check("reset_state", oSTATE, 3'd0);
        check("reset_outputs", {oCAP_EN, oLOAD, oRD, oWORD_VALID, oBUSY, oDONE, oERR}, 7'd0);
        check("reset_word_addr", {oWORD, oROW, oCOL}, 27'd0);
        // iSTART already high at reset release must not count as an edge
        iRST = 1'b0;
        repeat (3) @(negedge iCLK);
        check("no_edge_after_reset", oSTATE, 3'd0);
        iSTART = 1'b0;
        repeat (2) @(negedge iCLK);

        // nominal frame, word 5 held for 10 cycles
        load_readout(0, 5);
        load_cnt = 0;
        rd_cyc   = 0;
        start_pulse("nom");
        send_frame(NPIX, 1'b1, "nom");
        wait_state(3'd6, 3000, "nom_done_state");
        check("nom_done_flag", oDONE, 1'b1);
        check("nom_err", oERR, 1'b0);
        check("nom_busy", oBUSY, 1'b0);
        check("nom_load_pulses", load_cnt, 2);
        check("nom_rd_cycles", rd_cyc, NPIX);
        check("nom_queue_empty", exp_q.size(), 0);

        // start while a frame is already running
        load_readout(1, -1);
        iFVAL = 1'b1;
        repeat (5) begin
            iDVAL = 1'b1;
            @(negedge iCLK);
        end
        start_pulse("mid");
        cap_hi = 0;
        repeat (20) begin
            iDVAL = 1'($urandom_range(0, 1));
            @(negedge iCLK);
            if (oCAP_EN) cap_hi++;
        end
        check("mid_capen_low", cap_hi, 0);
        check("mid_still_arm", oSTATE, 3'd1);
        iDVAL = 1'b0;
        iFVAL = 1'b0;
        @(negedge iCLK);
        check("mid_wait_sof", oSTATE, 3'd2);
        send_frame(NPIX, 1'b1, "mid");
        wait_state(3'd6, 3000, "mid_done_state");
        check("mid_err", oERR, 1'b0);
        check("mid_queue_empty", exp_q.size(), 0);

        // short frame: one pixel missing
        rd_cyc = 0;
        start_pulse("short");
        send_frame(NPIX - 1, 1'b0, "short");
        repeat (20) @(negedge iCLK);
        check("short_no_rd", rd_cyc, 0);
        check("short_idle", oSTATE, 3'd0);

        // SOF timeout
        start_pulse("tmo");
        n = 0;
        while (oSTATE == 3'd2 && n < 500) begin
            n++;
            @(negedge iCLK);
        end
        check("tmo_cycles", n, TMO);
        check("tmo_state", oSTATE, 3'd0);
        check("tmo_err", oERR, 1'b1);

        // abort during READ
        load_readout(0, -1);
        start_pulse("abt");
        send_frame(NPIX, 1'b1, "abt");
        repeat (3) @(negedge iCLK);
        check("abt_reading", oRD, 1'b1);
        iABORT = 1'b1;
        @(negedge iCLK);
        check("abt_outputs", {oCAP_EN, oRD, oWORD_VALID, oLOAD}, 4'd0);
        check("abt_state", oSTATE, 3'd0);
        check("abt_err_kept", oERR, 1'b0);
        iABORT = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge iCLK);

        // asynchronous reset while word 3 is being presented
        load_readout(1, 3);
        start_pulse("rst");
        send_frame(NPIX, 1'b1, "rst");
        n = 0;
        while (!(oWORD_VALID && oCOL == 10'd24) && n < 2000) begin
            @(negedge iCLK);
            n++;
        end
        check("rst_word3_present", {oWORD_VALID, oROW, oCOL}, {1'b1, 9'd0, 10'd24});
        @(negedge iCLK);
        #2;
        iRST = 1'b1;
        #1;
        check("rst_async_state", oSTATE, 3'd0);
        check("rst_async_outputs", {oCAP_EN, oLOAD, oRD, oWORD_VALID, oBUSY, oDONE, oERR}, 7'd0);
        check("rst_async_word_addr", {oWORD, oROW, oCOL}, 27'd0);
        @(negedge iCLK);
        iRST = 1'b0;
        exp_q.delete();
        hold_word = -1;
        repeat (3) @(negedge iCLK);

        // clean frame after reset
        load_readout(1, -1);
        start_pulse("clean");
        send_frame(NPIX, 1'b1, "clean");
        wait_state(3'd6, 3000, "clean_done_state");
        check("clean_done_flag", oDONE, 1'b1);
        check("clean_err", oERR, 1'b0);
        check("clean_queue_empty", exp_q.size(), 0);

        repeat (2) @(negedge iCLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
